// File: rtl/io_pkg.sv
// io_pkg: IO page register map and shared constants.
// Also used by the system top and the firmware header generator.
package io_pkg;

  localparam logic [3:0] IO_LEDS     = 4'd0;
  localparam logic [3:0] IO_CTRL     = 4'd1;
  localparam logic [3:0] IO_COUNT    = 4'd2;
  localparam logic [3:0] IO_CMP      = 4'd3;
  localparam logic [3:0] IO_STATUS   = 4'd4;
  localparam logic [3:0] IO_SEG_BASE = 4'd8;

  localparam int IO_PAGE_BIT = 22;

  // Segment order inside a 7-bit channel: A is bit 6, G is bit 0.
  localparam int IO_SEG_A_BIT = 6;
  localparam int IO_SEG_G_BIT = 0;

  typedef enum logic {
    RD_IDLE,
    RD_WAIT
  } rd_state_e;

  function automatic logic [31:0] io_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  mask
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/io_tick_timer.sv
// io_tick_timer: prescaled tick counter with compare.
// Sticky match flag, set on increment into CMP, W1C.
module io_tick_timer
  import io_pkg::*;
#(
  parameter int PRESCALE = 12000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic        status_we,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        match
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [31:0]   count_nx;
  logic          tick;
  logic          hit;
  logic          clr;

  assign count_nx = count + 32'd1;
  assign tick     = en & (pre_q == PRE_MAX);
  // A COUNT write beats the tick, so it can never raise the flag.
  assign hit      = tick & ~count_we & (count_nx == cmp);
  assign clr      = status_we & wmask[0] & wdata[0];

  // Prescaler and COUNT; a write reloads COUNT and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      count <= '0;
    end else if (count_we) begin
      pre_q <= '0;
      count <= io_merge(count, wdata, wmask);
    end else if (tick) begin
      pre_q <= '0;
      count <= count_nx;
    end else if (en) begin
      pre_q <= pre_q + PW'(1);
    end else begin
      pre_q <= '0;
    end
  end

  // Compare register.
  always_ff @(posedge clk) begin
    if (reset) cmp <= 32'hFFFF_FFFF;
    else if (cmp_we) cmp <= io_merge(cmp, wdata, wmask);
  end

  // Sticky match flag; setting wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) match <= 1'b0;
    else if (hit) match <= 1'b1;
    else if (clr) match <= 1'b0;
  end

endmodule

// File: rtl/io_periph.sv
// io_periph: memory-mapped LEDs, seven-segment channels and tick timer.
// Registered readback with optional read wait states on io_rbusy.
module io_periph
  import io_pkg::*;
#(
  parameter int LED_WIDTH = 4,
  parameter int NUM_SEG   = 2,
  parameter int CLK_HZ    = 12000000,
  parameter int TICK_HZ   = 1000,
  parameter int READ_WAIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_sel,
  input  logic [3:0]           io_word_addr,
  input  logic                 mem_rstrb,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wmask,
  output logic [31:0]          io_rdata,
  output logic                 io_rbusy,
  output logic [LED_WIDTH-1:0] leds,
  output logic [7*NUM_SEG-1:0] seg,
  output logic                 timer_match
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam logic [2:0] RW_LAST = 3'(READ_WAIT - 1);

  logic                 we;
  logic                 rd_req;
  logic [LED_WIDTH-1:0] leds_q;
  logic                 ctrl_q;
  logic [6:0]           seg_q [NUM_SEG];
  logic [31:0]          count;
  logic [31:0]          cmp;
  logic                 match;
  logic [31:0]          rd_val;

  rd_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] rdata_d;

  assign we     = io_sel & (|mem_wmask);
  assign rd_req = io_sel & mem_rstrb;

  io_tick_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl_q),
    .count_we (we & (io_word_addr == IO_COUNT)),
    .cmp_we   (we & (io_word_addr == IO_CMP)),
    .status_we(we & (io_word_addr == IO_STATUS)),
    .wmask    (mem_wmask),
    .wdata    (mem_wdata),
    .count    (count),
    .cmp      (cmp),
    .match    (match)
  );

  // LED, CTRL and segment registers with byte-masked writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= '0;
      ctrl_q <= 1'b0;
      for (int k = 0; k < NUM_SEG; k++) seg_q[k] <= '0;
    end else if (we) begin
      if (io_word_addr == IO_LEDS)
        leds_q <= LED_WIDTH'(io_merge(32'(leds_q), mem_wdata, mem_wmask));
      if (io_word_addr == IO_CTRL && mem_wmask[0])
        ctrl_q <= mem_wdata[0];
      for (int k = 0; k < NUM_SEG; k++)
        if (io_word_addr == IO_SEG_BASE + 4'(k) && mem_wmask[0])
          seg_q[k] <= mem_wdata[6:0];
    end
  end

  // Readback mux of current (pre-write) register values.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (io_word_addr == IO_LEDS):   rd_val = 32'(leds_q);
      (io_word_addr == IO_CTRL):   rd_val = {31'd0, ctrl_q};
      (io_word_addr == IO_COUNT):  rd_val = count;
      (io_word_addr == IO_CMP):    rd_val = cmp;
      (io_word_addr == IO_STATUS): rd_val = {31'd0, match};
      default: ;
    endcase
    for (int k = 0; k < NUM_SEG; k++)
      if (io_word_addr == IO_SEG_BASE + 4'(k))
        rd_val = {25'd0, seg_q[k]};
  end

  // Read-wait state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RD_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      io_rdata <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      io_rdata <= rdata_d;
    end
  end

  // Read-wait next state: value is captured at the strobe, shown when busy drops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rdata_d = io_rdata;
    unique case (1'b1)
      (state_q == RD_IDLE): begin
        if (rd_req) begin
          if (READ_WAIT == 0) begin
            rdata_d = rd_val;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = RW_LAST;
            hold_d  = rd_val;
          end
        end
      end
      (state_q == RD_WAIT): begin
        if (cnt_q == 3'd0) begin
          state_d = RD_IDLE;
          rdata_d = hold_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  assign io_rbusy    = (state_q == RD_WAIT);
  assign leds        = leds_q;
  assign timer_match = match;

  // Pack channels, channel k at seg[7k+6:7k].
  always_comb begin
    seg = '0;
    for (int k = 0; k < NUM_SEG; k++) seg[7*k +: 7] = seg_q[k];
  end

endmodule

// File: tb/tb_io_periph.sv
// tb_io_periph: randomized and directed checks of io_periph.
// Two instances share stimulus: no read wait, and three wait cycles.
module tb_io_periph;

  localparam int LW  = 8;
  localparam int NS  = 4;
  localparam int PRE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          io_sel = 1'b0;
  logic          mem_rstrb = 1'b0;
  logic [3:0]    io_word_addr = '0;
  logic [3:0]    mem_wmask = '0;
  logic [31:0]   mem_wdata = '0;

  logic [31:0]   rd0, rd1;
  logic          busy0, busy1;
  logic [LW-1:0] leds0, leds1;
  logic [7*NS-1:0] seg0, seg1;
  logic          tm0, tm1;

  io_periph #(
    .LED_WIDTH(LW), .NUM_SEG(NS), .CLK_HZ(4000),
    .TICK_HZ(1000), .READ_WAIT(0)
  ) dut0 (
    .clk(clk), .reset(reset), .io_sel(io_sel),
    .io_word_addr(io_word_addr), .mem_rstrb(mem_rstrb),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .io_rdata(rd0), .io_rbusy(busy0), .leds(leds0),
    .seg(seg0), .timer_match(tm0)
  );

  io_periph #(
    .LED_WIDTH(LW), .NUM_SEG(NS), .CLK_HZ(4000),
    .TICK_HZ(1000), .READ_WAIT(3)
  ) dut1 (
    .clk(clk), .reset(reset), .io_sel(io_sel),
    .io_word_addr(io_word_addr), .mem_rstrb(mem_rstrb),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .io_rdata(rd1), .io_rbusy(busy1), .leds(leds1),
    .seg(seg1), .timer_match(tm1)
  );

  int errs = 0;
  int checks = 0;

  // Reference model of the register file (instance with no read wait).
  logic [31:0] m_leds, m_count, m_cmp, m_rd;
  logic        m_ctrl, m_status;
  logic [6:0]  m_seg [NS];
  int          m_pre;

  function automatic logic [31:0] mmerge(
    input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [3:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return m_leds;
    if (ai == 1) return {31'd0, m_ctrl};
    if (ai == 2) return m_count;
    if (ai == 3) return m_cmp;
    if (ai == 4) return {31'd0, m_status};
    if (ai >= 8 && ai < 8 + NS) return {25'd0, m_seg[ai-8]};
    return 32'd0;
  endfunction

  function automatic logic [7*NS-1:0] seg_vec();
    logic [7*NS-1:0] v;
    for (int k = 0; k < NS; k++) v[7*k +: 7] = m_seg[k];
    return v;
  endfunction

  task automatic model_reset();
    m_leds = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_rd = 0;
    m_ctrl = 0; m_status = 0; m_pre = 0;
    for (int k = 0; k < NS; k++) m_seg[k] = 0;
  endtask

  // One clock: advance the model from pre-edge state, then settle.
  task automatic step();
    logic [31:0] rv;
    logic we, set;
    int ai;
    @(posedge clk);
    rv = mread(io_word_addr);
    ai = int'(io_word_addr);
    if (reset) begin
      model_reset();
    end else begin
      we = io_sel && (mem_wmask != 0);
      if (io_sel && mem_rstrb) m_rd = rv;
      set = 0;
      if (we && ai == 2) begin
        m_count = mmerge(m_count, mem_wdata, mem_wmask);
        m_pre = 0;
      end else if (m_ctrl) begin
        if (m_pre == PRE - 1) begin
          m_pre = 0;
          m_count = m_count + 32'd1;
          set = (m_count == m_cmp);
        end else begin
          m_pre++;
        end
      end else begin
        m_pre = 0;
      end
      if (set) m_status = 1;
      else if (we && ai == 4 && mem_wmask[0] && mem_wdata[0]) m_status = 0;
      if (we) begin
        if (ai == 0) m_leds = mmerge(m_leds, mem_wdata, mem_wmask) & 32'hFF;
        if (ai == 1 && mem_wmask[0]) m_ctrl = mem_wdata[0];
        if (ai == 3) m_cmp = mmerge(m_cmp, mem_wdata, mem_wmask);
        if (ai >= 8 && ai < 8 + NS && mem_wmask[0]) m_seg[ai-8] = mem_wdata[6:0];
      end
    end
    #1;
  endtask

  task automatic idle();
    io_sel = 0; mem_rstrb = 0; mem_wmask = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    io_sel = 1; mem_rstrb = 0; io_word_addr = a; mem_wdata = d; mem_wmask = m;
    step();
    idle();
  endtask

  task automatic rd(input logic [3:0] a);
    io_sel = 1; mem_rstrb = 1; io_word_addr = a; mem_wmask = 0;
    step();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    reset = 1; step(); step(); reset = 0;
    checks++; if (rd0 !== 32'd0) begin errs++; $display("FAIL reset_rdata got %h exp 0", rd0); end
    checks++; if (busy0 !== 1'b0) begin errs++; $display("FAIL reset_busy0 got %b exp 0", busy0); end
    checks++; if (busy1 !== 1'b0) begin errs++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    checks++; if (leds0 !== '0) begin errs++; $display("FAIL reset_leds got %h exp 0", leds0); end
    checks++; if (seg0 !== '0) begin errs++; $display("FAIL reset_seg got %h exp 0", seg0); end
    checks++; if (tm0 !== 1'b0) begin errs++; $display("FAIL reset_match got %b exp 0", tm0); end
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      exp = (i == 3) ? 32'hFFFF_FFFF : 32'd0;
      checks++;
      if (rd0 !== exp) begin errs++; $display("FAIL reset_read idx%0d got %h exp %h", i, rd0, exp); end
      checks++;
      if (busy0 !== 1'b0) begin errs++; $display("FAIL reset_read_busy idx%0d got %b exp 0", i, busy0); end
    end
  endtask

  task automatic test_leds_seg();
    wr(4'd0, 32'hF, 4'hF);
    wr(4'd9, 32'h7F, 4'b0001);
    wr(4'd9, 32'h0, 4'b0010);
    checks++; if (leds0 !== 8'h0F) begin errs++; $display("FAIL leds_out got %h exp 0f", leds0); end
    checks++; if (seg0[13:7] !== 7'h7F) begin errs++; $display("FAIL seg1_out got %h exp 7f", seg0[13:7]); end
    rd(4'd9);
    checks++; if (rd0 !== 32'h7F) begin errs++; $display("FAIL seg1_read got %h exp 7f", rd0); end
    rd(4'd0);
    checks++; if (rd0 !== 32'hF) begin errs++; $display("FAIL leds_read got %h exp f", rd0); end
    wr(4'd0, 32'h1FF, 4'hF);
    rd(4'd0);
    checks++; if (rd0 !== 32'hFF) begin errs++; $display("FAIL leds_trunc got %h exp ff", rd0); end
    wr(4'd0, 32'h0, 4'b0010);
    checks++; if (leds0 !== 8'hFF) begin errs++; $display("FAIL leds_mask got %h exp ff", leds0); end
    wr(4'd11, 32'hFFFF_FF2A, 4'hF);
    rd(4'd11);
    checks++; if (rd0 !== 32'h2A) begin errs++; $display("FAIL seg3_read got %h exp 2a", rd0); end
    checks++; if (seg0[27:21] !== 7'h2A) begin errs++; $display("FAIL seg3_out got %h exp 2a", seg0[27:21]); end
    wr(4'd12, 32'h55, 4'hF);
    rd(4'd12);
    checks++; if (rd0 !== 32'd0) begin errs++; $display("FAIL idx12_read got %h exp 0", rd0); end
  endtask

  task automatic test_timer_match();
    int hit_at;
    logic coinc, done;
    wr(4'd1, 32'd0, 4'h1);
    wr(4'd3, 32'd3, 4'hF);
    wr(4'd2, 32'd0, 4'hF);
    wr(4'd4, 32'd1, 4'h1);
    wr(4'd1, 32'd1, 4'h1);
    hit_at = 0;
    for (int n = 1; n <= 40; n++) begin
      io_sel = 1; io_word_addr = 4'd2; mem_rstrb = 1; mem_wmask = 0;
      step();
      checks++; if (rd0 !== m_rd) begin errs++; $display("FAIL tick_count n%0d got %h exp %h", n, rd0, m_rd); end
      checks++; if (tm0 !== m_status) begin errs++; $display("FAIL tick_match n%0d got %b exp %b", n, tm0, m_status); end
      if (m_status) begin hit_at = n; break; end
    end
    idle();
    checks++; if (hit_at != 12 || tm0 !== 1'b1) begin errs++; $display("FAIL match_cycle got %0d/%b exp 12/1", hit_at, tm0); end
    rd(4'd2);
    checks++; if (rd0 !== 32'd3) begin errs++; $display("FAIL match_count got %h exp 3", rd0); end
    wr(4'd4, 32'd1, 4'h1);
    checks++; if (tm0 !== 1'b0) begin errs++; $display("FAIL w1c_clear got %b exp 0", tm0); end
    wr(4'd2, 32'd0, 4'hF);
    done = 0;
    for (int n = 0; n < 40; n++) begin
      coinc = m_ctrl && m_pre == PRE - 1 && (m_count + 32'd1) == m_cmp;
      if (coinc) begin
        io_sel = 1; io_word_addr = 4'd4; mem_wdata = 32'd1; mem_wmask = 4'h1; mem_rstrb = 0;
      end
      step();
      idle();
      checks++; if (tm0 !== m_status) begin errs++; $display("FAIL coinc_track n%0d got %b exp %b", n, tm0, m_status); end
      if (coinc) begin done = 1; break; end
    end
    checks++; if (!done || tm0 !== 1'b1) begin errs++; $display("FAIL set_beats_clear got %b/%b exp 1/1", done, tm0); end
  endtask

  task automatic test_wrap();
    logic found;
    logic [31:0] exp;
    wr(4'd4, 32'd1, 4'h1);
    wr(4'd3, 32'hFFFF_FFFF, 4'hF);
    wr(4'd2, 32'hFFFF_FFFF, 4'hF);
    for (int n = 0; n < 10 && m_count != 0; n++) step();
    rd(4'd2);
    checks++; if (rd0 !== 32'd0) begin errs++; $display("FAIL wrap_count got %h exp 0", rd0); end
    checks++; if (tm0 !== 1'b0) begin errs++; $display("FAIL wrap_nomatch got %b exp 0", tm0); end
    found = 0;
    for (int n = 0; n < 8; n++) begin
      if (m_pre == PRE - 1) begin found = 1; break; end
      step();
    end
    checks++; if (!found) begin errs++; $display("FAIL find_tick got 0 exp 1"); end
    wr(4'd2, 32'd5, 4'hF);
    for (int i = 0; i < 5; i++) begin
      rd(4'd2);
      exp = (i < 4) ? 32'd5 : 32'd6;
      checks++;
      if (rd0 !== exp) begin errs++; $display("FAIL load_vs_tick i%0d got %h exp %h", i, rd0, exp); end
    end
  endtask

  task automatic test_read_wait();
    reset = 1; step(); reset = 0;
    wr(4'd2, 32'h1234, 4'hF);
    io_sel = 1; io_word_addr = 4'd2; mem_rstrb = 1; step();
    checks++; if (busy1 !== 1'b1 || rd1 !== 32'd0) begin errs++; $display("FAIL rw_c1 got %b/%h exp 1/0", busy1, rd1); end
    checks++; if (busy0 !== 1'b0) begin errs++; $display("FAIL rw0_busy got %b exp 0", busy0); end
    io_word_addr = 4'd3; step(); idle();
    checks++; if (busy1 !== 1'b1 || rd1 !== 32'd0) begin errs++; $display("FAIL rw_c2 got %b/%h exp 1/0", busy1, rd1); end
    step();
    checks++; if (busy1 !== 1'b1 || rd1 !== 32'd0) begin errs++; $display("FAIL rw_c3 got %b/%h exp 1/0", busy1, rd1); end
    step();
    checks++; if (busy1 !== 1'b0 || rd1 !== 32'h1234) begin errs++; $display("FAIL rw_done got %b/%h exp 0/1234", busy1, rd1); end
    step();
    checks++; if (busy1 !== 1'b0 || rd1 !== 32'h1234) begin errs++; $display("FAIL rw_ignored got %b/%h exp 0/1234", busy1, rd1); end
    rd(4'd3); step(); step(); step();
    checks++; if (busy1 !== 1'b0 || rd1 !== 32'hFFFF_FFFF) begin errs++; $display("FAIL rw_next got %b/%h exp 0/ffffffff", busy1, rd1); end
    rd(4'd2); step();
    checks++; if (busy1 !== 1'b1) begin errs++; $display("FAIL rw_busy2 got %b exp 1", busy1); end
    reset = 1; step(); reset = 0;
    checks++; if (busy1 !== 1'b0 || rd1 !== 32'd0) begin errs++; $display("FAIL rw_abort got %b/%h exp 0/0", busy1, rd1); end
  endtask

  task automatic test_random();
    wr(4'd3, 32'd6, 4'hF);
    wr(4'd2, 32'd0, 4'hF);
    wr(4'd1, 32'd1, 4'h1);
    for (int n = 0; n < 400; n++) begin
      io_sel = ($urandom_range(0, 3) != 0);
      io_word_addr = 4'($urandom_range(0, 15));
      mem_rstrb = 1'($urandom_range(0, 1));
      mem_wmask = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      mem_wdata = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 8));
      step();
      checks++; if (rd0 !== m_rd) begin errs++; $display("FAIL rnd_rdata n%0d got %h exp %h", n, rd0, m_rd); end
      checks++; if (leds0 !== m_leds[LW-1:0]) begin errs++; $display("FAIL rnd_leds n%0d got %h exp %h", n, leds0, m_leds[LW-1:0]); end
      checks++; if (seg0 !== seg_vec()) begin errs++; $display("FAIL rnd_seg n%0d got %h exp %h", n, seg0, seg_vec()); end
      checks++; if (tm0 !== m_status) begin errs++; $display("FAIL rnd_match n%0d got %b exp %b", n, tm0, m_status); end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_leds_seg();
    test_timer_match();
    test_wrap();
    test_read_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
